alu_pipe_seq: RTL and testbench

//  Parametrised, clocked successor of the 3-bit-opcode combinational ALU. Accepts one operation
//  per valid/ready handshake and returns a registered result with zer/neg/cout/ovf flags.

---
 rtl/alu_pipe_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_pipe_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_seq.sv
// Clocked ALU with valid/ready handshake. Single-cycle ADD/SUB/logic/shift ops and an
// iterative shift-add multiply (one multiplier bit per cycle). Result and flags are
// registered and held until the consumer takes them.
module alu_pipe_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             inC,
   input  logic [2:0]       opc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] w,
   output logic             zer,
   output logic             neg,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned SW = $clog2(WIDTH);
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CntLast = CW'(WIDTH);

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpAnd = 3'b010;
   localparam logic [2:0] OpOr  = 3'b011;
   localparam logic [2:0] OpXor = 3'b100;
   localparam logic [2:0] OpShl = 3'b101;
   localparam logic [2:0] OpSra = 3'b110;
   localparam logic [2:0] OpMul = 3'b111;

   typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

   state_e               state_q;
   logic                 out_valid_q;
   logic [WIDTH-1:0]     w_q;
   logic                 zer_q, neg_q, cout_q, ovf_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [CW-1:0]        cnt_q;

   logic [WIDTH-1:0]     res_w;
   logic                 res_c;
   logic                 res_v;
   logic [WIDTH:0]       sum;
   logic signed [WIDTH:0] sra_ext;
   logic [SW-1:0]        sh_amt;
   logic [2*WIDTH-1:0]   acc_nxt;

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign w         = w_q;
   assign zer       = zer_q;
   assign neg       = neg_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

   assign sh_amt  = inB[SW-1:0];
   // Add the shifted multiplicand when the current multiplier LSB is set.
   assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   // Single-cycle result and flags from the live inputs; used only at the accept edge.
   always_comb begin
      res_w   = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      sum     = '0;
      sra_ext = '0;
      unique case (opc)
         OpAdd: begin
            sum   = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, inC};
            res_w = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (inA[WIDTH-1] == inB[WIDTH-1]) && (res_w[WIDTH-1] != inA[WIDTH-1]);
         end
         OpSub: begin
            // Top bit of the widened difference is the borrow.
            sum   = {1'b0, inA} - {1'b0, inB} - {{WIDTH{1'b0}}, inC};
            res_w = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (inA[WIDTH-1] != inB[WIDTH-1]) && (res_w[WIDTH-1] != inA[WIDTH-1]);
         end
         OpAnd: res_w = inA & inB;
         OpOr:  res_w = inA | inB;
         OpXor: res_w = inA ^ inB;
         OpShl: {res_c, res_w} = {1'b0, inA} << sh_amt;
         OpSra: begin
            // Extra guard bit below the LSB catches the last bit shifted out.
            sra_ext        = $signed({inA, 1'b0}) >>> sh_amt;
            {res_w, res_c} = sra_ext;
         end
         OpMul: res_w = '0;
         default: res_w = '0;
      endcase
   end

   // Control FSM, multiply datapath and registered result/flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         w_q         <= '0;
         zer_q       <= 1'b0;
         neg_q       <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  if (opc == OpMul) begin
                     acc_q    <= '0;
                     mcand_q  <= {{WIDTH{1'b0}}, inA};
                     mplier_q <= inB;
                     cnt_q    <= '0;
                     state_q  <= StMul;
                  end else begin
                     w_q         <= res_w;
                     zer_q       <= (res_w == '0);
                     neg_q       <= res_w[WIDTH-1];
                     cout_q      <= res_c;
                     ovf_q       <= res_v;
                     out_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end
               end
            end
            StMul: begin
               if (cnt_q == CntLast) begin
                  w_q         <= acc_q[WIDTH-1:0];
                  zer_q       <= (acc_q[WIDTH-1:0] == '0);
                  neg_q       <= acc_q[WIDTH-1];
                  cout_q      <= |acc_q[2*WIDTH-1:WIDTH];
                  ovf_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  acc_q    <= acc_nxt;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  cnt_q    <= cnt_q + 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe_seq.sv
// Directed bench for alu_pipe_seq at WIDTH=16 with hand-computed expectations.
module tb_alu_pipe_seq;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] inA = '0;
   logic [W-1:0] inB = '0;
   logic         inC = 1'b0;
   logic [2:0]   opc = 3'b000;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] w;
   logic         zer, neg, cout, ovf;

   int compared   = 0;
   int mismatched = 0;

   alu_pipe_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inA       (inA),
      .inB       (inB),
      .inC       (inC),
      .opc       (opc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .w         (w),
      .zer       (zer),
      .neg       (neg),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one op for a single accept edge; returns at the negedge after that edge.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
      @(negedge clk);
      opc = op; inA = a; inB = b; inC = c; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      inA = '1; inB = '1; inC = 1'b1; opc = 3'b010;
   endtask

   task automatic chk_res(input string tag, input logic [W-1:0] ew, input logic ez,
                          input logic en, input logic ec, input logic ev);
      chk({tag, ".valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".w"},     64'(w),         64'(ew));
      chk({tag, ".zer"},   64'(zer),       64'(ez));
      chk({tag, ".neg"},   64'(neg),       64'(en));
      chk({tag, ".cout"},  64'(cout),      64'(ec));
      chk({tag, ".ovf"},   64'(ovf),       64'(ev));
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".drop_valid"}, 64'(out_valid), 64'd0);
      chk({tag, ".ready_back"}, 64'(in_ready),  64'd1);
   endtask

   // Wait for a MUL result; reports edges since acceptance and in_ready leaks.
   task automatic wait_mul(output int lat, output int rdy_seen);
      lat = 0;
      rdy_seen = 0;
      if (in_ready) rdy_seen++;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
         if (in_ready) rdy_seen++;
      end
   endtask

   initial begin
      int lat, rdy;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst.in_ready",  64'(in_ready),  64'd1);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.w",         64'(w),         64'd0);
      chk("rst.flags",     64'({zer, neg, cout, ovf}), 64'd0);

      // Signed overflow on ADD
      issue(3'b000, 16'h7FFF, 16'h0001, 1'b0);
      chk_res("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
      consume("add_ovf");

      // ADD with carry-in wrapping to zero
      issue(3'b000, 16'hFFFF, 16'h0000, 1'b1);
      chk_res("add_cin", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
      consume("add_cin");

      issue(3'b001, 16'h0005, 16'h0005, 1'b0);
      chk_res("sub_zero", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      consume("sub_zero");

      issue(3'b001, 16'h0000, 16'h0001, 1'b0);
      chk_res("sub_borrow", 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
      consume("sub_borrow");

      // Borrow-in alone produces the borrow
      issue(3'b001, 16'h0005, 16'h0005, 1'b1);
      chk_res("sub_bin", 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
      consume("sub_bin");

      issue(3'b001, 16'h8000, 16'h0001, 1'b0);
      chk_res("sub_ovf", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
      consume("sub_ovf");

      // Carry-in must not leak into logic ops
      issue(3'b010, 16'hF0F0, 16'hFF00, 1'b1);
      chk_res("and", 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0);
      consume("and");

      issue(3'b011, 16'h0F00, 16'h00F0, 1'b0);
      chk_res("or", 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
      consume("or");

      issue(3'b100, 16'hAAAA, 16'hAAAA, 1'b0);
      chk_res("xor", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      consume("xor");

      issue(3'b110, 16'h8000, 16'h0004, 1'b0);
      chk_res("sra4", 16'hF800, 1'b0, 1'b1, 1'b0, 1'b0);
      consume("sra4");

      issue(3'b110, 16'h7FF1, 16'h0001, 1'b0);
      chk_res("sra1", 16'h3FF8, 1'b0, 1'b0, 1'b1, 1'b0);
      consume("sra1");

      issue(3'b101, 16'h8001, 16'h0001, 1'b0);
      chk_res("shl1", 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0);
      consume("shl1");

      // Zero shift: no shift-out; upper bits of inB ignored
      issue(3'b101, 16'h8001, 16'hFFF0, 1'b0);
      chk_res("shl0", 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0);
      consume("shl0");

      // MUL: 0x100 * 0x100 = 0x10000
      issue(3'b111, 16'h0100, 16'h0100, 1'b0);
      wait_mul(lat, rdy);
      chk("mul1.latency", 64'(lat), 64'd17);
      chk("mul1.ready_lo", 64'(rdy), 64'd0);
      chk_res("mul1", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
      consume("mul1");

      issue(3'b111, 16'h00FF, 16'h00FF, 1'b0);
      wait_mul(lat, rdy);
      chk("mul2.latency", 64'(lat), 64'd17);
      chk_res("mul2", 16'hFE01, 1'b0, 1'b1, 1'b0, 1'b0);
      consume("mul2");

      // Back-pressure: result held, new ops ignored
      issue(3'b000, 16'h0003, 16'h0004, 1'b0);
      opc = 3'b001; inA = 16'hFFFF; inB = 16'h0001; in_valid = 1'b1;
      repeat (5) @(negedge clk);
      chk("hold.in_ready", 64'(in_ready), 64'd0);
      chk_res("hold", 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      consume("hold");
      @(negedge clk);
      chk("hold.no_queue", 64'(out_valid), 64'd0);

      // Reset aborts a MUL in flight
      issue(3'b111, 16'h1234, 16'h5678, 1'b0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort.out_valid", 64'(out_valid), 64'd0);
      chk("abort.w",         64'(w),         64'd0);
      chk("abort.in_ready",  64'(in_ready),  64'd1);
      repeat (20) @(negedge clk);
      chk("abort.no_result", 64'(out_valid), 64'd0);

      issue(3'b000, 16'h0003, 16'h0004, 1'b0);
      chk_res("post_rst", 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
      consume("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
